// File: rtl/muldiv_ctrl_pkg.sv
// Shared pipeline package: mult/div opcodes, FSM states and default latencies.
package muldiv_ctrl_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned MUL_LAT_DEF  = 2;
  localparam int unsigned DIV_BITS_DEF = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_t;

  // Divide ops have the upper opcode bit set.
  function automatic logic op_is_div(input muldiv_op_t op);
    return op[1];
  endfunction

  // Signed ops have the lower opcode bit clear.
  function automatic logic op_is_signed(input muldiv_op_t op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_ctrl_div_iter.sv
// Unsigned restoring divider, one quotient bit per clock.
module div_iter
  import muldiv_ctrl_pkg::*;
#(
  parameter int unsigned DIV_BITS = DIV_BITS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic [XLEN-1:0]   i_dividend,
  input  logic [XLEN-1:0]   i_divisor,
  output logic              o_done,
  output logic [XLEN-1:0]   o_quotient,
  output logic [XLEN-1:0]   o_remainder
);

  localparam int unsigned CNT_W = $clog2(DIV_BITS + 1);

  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_quo;
  logic [XLEN-1:0]  r_rem;
  logic [XLEN-1:0]  r_dvs;
  logic [XLEN:0]    w_shift;
  logic [XLEN:0]    w_diff;

  // Shift in the next dividend bit and trial-subtract the divisor.
  assign w_shift = {r_rem, r_quo[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs};

  // Load on start, then one restoring step per cycle until the count expires.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_quo <= '0;
      r_rem <= '0;
      r_dvs <= '0;
    end else if (i_start) begin
      r_cnt <= CNT_W'(DIV_BITS);
      r_quo <= i_dividend;
      r_rem <= '0;
      r_dvs <= i_divisor;
    end else if (r_cnt != '0) begin
      if (!w_diff[XLEN]) begin
        r_rem <= w_diff[XLEN-1:0];
        r_quo <= {r_quo[XLEN-2:0], 1'b1};
      end else begin
        r_rem <= w_shift[XLEN-1:0];
        r_quo <= {r_quo[XLEN-2:0], 1'b0};
      end
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // High in the cycle whose closing edge performs the final iteration.
  assign o_done      = (r_cnt == CNT_W'(1));
  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;

endmodule

// File: rtl/muldiv_ctrl.sv
// Execute-stage multiply/divide sequencer with stall, flush and sign fix-up.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT  = MUL_LAT_DEF,
  parameter int unsigned DIV_BITS = DIV_BITS_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  input  muldiv_op_t      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic            flush,
  input  logic            advance,
  output logic            stall,
  output logic            res_valid,
  output logic [XLEN-1:0] res_hi,
  output logic [XLEN-1:0] res_lo
);

  localparam int unsigned MCNT_W = 3;

  md_state_t           r_state;
  md_state_t           w_next;
  logic                w_accept;
  logic                w_div_start;
  logic                w_req_div;
  logic                w_req_dz;
  logic                w_a_neg;
  logic                w_b_neg;
  logic                w_div_done;
  logic [XLEN-1:0]     w_quo;
  logic [XLEN-1:0]     w_rem;
  logic [2*XLEN-1:0]   w_prod_fix;

  logic                r_is_div;
  logic                r_dz;
  logic                r_sa;
  logic                r_sb;
  logic [XLEN-1:0]     r_a;
  logic [XLEN-1:0]     r_b;
  logic [MCNT_W-1:0]   r_mcnt;
  logic [2*XLEN-1:0]   r_prod;

  // Request decode: op class, divide-by-zero and operand signs.
  assign w_req_div = op_is_div(req_op);
  assign w_req_dz  = w_req_div && (req_b == '0);
  assign w_a_neg   = op_is_signed(req_op) && req_a[XLEN-1];
  assign w_b_neg   = op_is_signed(req_op) && req_b[XLEN-1];

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; flush overrides everything, including a new request.
  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_div_start = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_accept = 1'b1;
          if (w_req_dz) begin
            w_next = ST_DONE;
          end else if (w_req_div) begin
            w_next      = ST_DIV;
            w_div_start = 1'b1;
          end else begin
            w_next = ST_MUL;
          end
        end
      end
      ST_MUL:  if (r_mcnt == '0) w_next = ST_DONE;
      ST_DIV:  if (w_div_done)   w_next = ST_DONE;
      ST_DONE: if (advance)      w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    if (flush) begin
      w_next      = ST_IDLE;
      w_accept    = 1'b0;
      w_div_start = 1'b0;
    end
  end

  // Operand capture at acceptance and the registered multiply during MUL.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_is_div <= 1'b0;
      r_dz     <= 1'b0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_mcnt   <= '0;
      r_prod   <= '0;
    end else if (w_accept) begin
      r_is_div <= w_req_div;
      r_dz     <= w_req_dz;
      r_sa     <= w_a_neg;
      r_sb     <= w_b_neg;
      r_a      <= (w_a_neg && !w_req_dz) ? (~req_a + XLEN'(1)) : req_a;
      r_b      <= w_b_neg ? (~req_b + XLEN'(1)) : req_b;
      r_mcnt   <= MCNT_W'(MUL_LAT - 1);
    end else if (r_state == ST_MUL) begin
      r_prod <= (2*XLEN)'(r_a) * (2*XLEN)'(r_b);
      if (r_mcnt != '0) r_mcnt <= r_mcnt - MCNT_W'(1);
    end
  end

  div_iter #(
    .DIV_BITS (DIV_BITS)
  ) u_div_iter (
    .clk         (clk),
    .reset       (reset),
    .i_start     (w_div_start),
    .i_dividend  (r_a_next_dividend()),
    .i_divisor   (r_b_next_divisor()),
    .o_done      (w_div_done),
    .o_quotient  (w_quo),
    .o_remainder (w_rem)
  );

  // Divider operands are the request magnitudes, loaded on the accepting edge.
  function automatic logic [XLEN-1:0] r_a_next_dividend();
    return w_a_neg ? (~req_a + XLEN'(1)) : req_a;
  endfunction

  function automatic logic [XLEN-1:0] r_b_next_divisor();
    return w_b_neg ? (~req_b + XLEN'(1)) : req_b;
  endfunction

  // Stall/result outputs with sign fix-up; all zero under reset or flush.
  always_comb begin
    stall      = 1'b0;
    res_valid  = 1'b0;
    res_hi     = '0;
    res_lo     = '0;
    w_prod_fix = (r_sa ^ r_sb) ? (~r_prod + (2*XLEN)'(1)) : r_prod;
    if (!reset && !flush) begin
      stall = (r_state == ST_MUL) || (r_state == ST_DIV) ||
              ((r_state == ST_IDLE) && req_valid);
      if (r_state == ST_DONE) begin
        res_valid = 1'b1;
        if (r_dz) begin
          res_hi = r_a;
          res_lo = '1;
        end else if (r_is_div) begin
          res_lo = (r_sa ^ r_sb) ? (~w_quo + XLEN'(1)) : w_quo;
          res_hi = r_sa ? (~w_rem + XLEN'(1)) : w_rem;
        end else begin
          res_hi = w_prod_fix[2*XLEN-1:XLEN];
          res_lo = w_prod_fix[XLEN-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized self-checking bench for muldiv_ctrl against an arithmetic model.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  localparam int unsigned MUL_LAT  = 2;
  localparam int unsigned DIV_BITS = 32;

  logic        clk;
  logic        reset;
  logic        req_valid;
  muldiv_op_t  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        flush;
  logic        advance;
  logic        stall;
  logic        res_valid;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  int n_chk  = 0;
  int n_fail = 0;

  muldiv_ctrl #(
    .MUL_LAT  (MUL_LAT),
    .DIV_BITS (DIV_BITS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .flush     (flush),
    .advance   (advance),
    .stall     (stall),
    .res_valid (res_valid),
    .res_hi    (res_hi),
    .res_lo    (res_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain signed/unsigned 64-bit arithmetic plus expected latency.
  function automatic void model(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo, output int lat);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    p  = '0;
    hi = '0;
    lo = '0;
    if ((op == MD_DIV || op == MD_DIVU) && b == 32'd0) begin
      hi  = a;
      lo  = 32'hFFFF_FFFF;
      lat = 1;
    end else begin
      case (op)
        MD_MULT: begin
          p = 64'(sa * sb);
          hi = p[63:32]; lo = p[31:0]; lat = MUL_LAT + 1;
        end
        MD_MULTU: begin
          p = {32'd0, a} * {32'd0, b};
          hi = p[63:32]; lo = p[31:0]; lat = MUL_LAT + 1;
        end
        MD_DIV: begin
          q = sa / sb;
          r = sa % sb;
          lo = 32'(q); hi = 32'(r); lat = DIV_BITS + 1;
        end
        default: begin
          lo = a / b; hi = a % b; lat = DIV_BITS + 1;
        end
      endcase
    end
  endfunction

  // Issue one instruction from IDLE and check stall, latency and result.
  task automatic do_op(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                       input string tag);
    logic [31:0] eh, el;
    int          lat, cyc;
    bit          got;
    model(op, a, b, eh, el, lat);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    advance = 1'b0; flush = 1'b0;
    #1;
    n_chk++;
    if (stall !== 1'b1 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s accept: stall=%b res_valid=%b, need stall=1 res_valid=0", tag, stall, res_valid);
    end
    cyc = 0; got = 0;
    while (!got && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (res_valid === 1'b1) got = 1;
      else begin
        n_chk++;
        if (stall !== 1'b1 || res_hi !== 32'd0 || res_lo !== 32'd0) begin
          n_fail++;
          $display("FAIL %s busy: stall=%b hi=%h lo=%h at cycle %0d, need stall=1 and zero results",
                   tag, stall, res_hi, res_lo, cyc);
        end
      end
    end
    n_chk++;
    if (!got || cyc != lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d (seen=%0d), need %0d", tag, cyc, got, lat);
    end
    n_chk++;
    if (res_hi !== eh || res_lo !== el) begin
      n_fail++;
      $display("FAIL %s result: hi=%h lo=%h, need hi=%h lo=%h", tag, res_hi, res_lo, eh, el);
    end
    n_chk++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_stall: stall=%b, need 0", tag, stall);
    end
  endtask

  // Hold DONE for some cycles checking stability, then advance out.
  task automatic retire(input int hold, input string tag);
    logic [31:0] h0, l0;
    h0 = res_hi; l0 = res_lo;
    advance = 1'b0;
    repeat (hold) begin
      @(posedge clk); #1;
      n_chk++;
      if (res_valid !== 1'b1 || res_hi !== h0 || res_lo !== l0) begin
        n_fail++;
        $display("FAIL %s hold: valid=%b hi=%h lo=%h, need valid=1 hi=%h lo=%h",
                 tag, res_valid, res_hi, res_lo, h0, l0);
      end
    end
    advance = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    advance = 1'b0;
    n_chk++;
    if (res_valid !== 1'b0 || stall !== 1'b0 || res_hi !== 32'd0 || res_lo !== 32'd0) begin
      n_fail++;
      $display("FAIL %s retire: valid=%b stall=%b hi=%h lo=%h, need all zero",
               tag, res_valid, stall, res_hi, res_lo);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b1; req_op = MD_MULT; req_a = 32'd3; req_b = 32'd4;
    flush = 1'b0; advance = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (stall !== 1'b0 || res_valid !== 1'b0 || res_hi !== 32'd0 || res_lo !== 32'd0) begin
      n_fail++;
      $display("FAIL reset: stall=%b valid=%b hi=%h lo=%h, need all zero", stall, res_valid, res_hi, res_lo);
    end
    reset = 1'b0; req_valid = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (stall !== 1'b0 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: stall=%b valid=%b, need 0 0", stall, res_valid);
    end
  endtask

  task automatic test_directed();
    do_op(MD_MULT,  32'hFFFF_FFFE, 32'd3, "mult_neg2x3");          retire(0, "mult_neg2x3");
    do_op(MD_DIV,   32'hFFFF_FFF9, 32'd2, "div_neg7_2");           retire(1, "div_neg7_2");
    do_op(MD_DIVU,  32'hFFFF_FFF9, 32'd2, "divu_neg7_2");          retire(0, "divu_neg7_2");
    do_op(MD_DIVU,  32'd5, 32'd0, "divu_by_zero");                 retire(1, "divu_by_zero");
    do_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_minint");   retire(0, "div_minint");
    do_op(MD_DIV,   32'h8000_0005, 32'd0, "div_by_zero_neg");      retire(0, "div_by_zero_neg");
  endtask

  task automatic test_flush_div();
    req_valid = 1'b1; req_op = MD_DIV; req_a = 32'd100; req_b = 32'd7;
    @(posedge clk); #1;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    #1;
    n_chk++;
    if (stall !== 1'b0 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_cycle: stall=%b valid=%b, need 0 0", stall, res_valid);
    end
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      n_chk++;
      if (stall !== 1'b0 || res_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_idle: stall=%b valid=%b at cycle %0d, need 0 0", stall, res_valid, i);
      end
    end
    do_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_after_flush");
    retire(0, "multu_after_flush");
  endtask

  task automatic test_back_to_back();
    do_op(MD_MULT, 32'd12345, 32'hFFFF_FF00, "hold_mult");
    advance = 1'b0;
    for (int i = 0; i < 5; i++) begin
      logic [31:0] h0, l0;
      h0 = res_hi; l0 = res_lo;
      @(posedge clk); #1;
      n_chk++;
      if (res_valid !== 1'b1 || res_hi !== h0 || res_lo !== l0) begin
        n_fail++;
        $display("FAIL hold_stable: valid=%b hi=%h lo=%h, need valid=1 hi=%h lo=%h",
                 res_valid, res_hi, res_lo, h0, l0);
      end
    end
    advance = 1'b1; req_valid = 1'b1; req_op = MD_MULT; req_a = 32'd2; req_b = 32'd3;
    @(posedge clk); #1;
    do_op(MD_MULT, 32'd2, 32'd3, "b2b_mult_2x3");
    retire(0, "b2b_mult_2x3");
  endtask

  task automatic test_reset_mid_mul();
    req_valid = 1'b1; req_op = MD_MULT; req_a = 32'd7; req_b = 32'd9;
    @(posedge clk); #1;
    #2 reset = 1'b1;
    #1;
    n_chk++;
    if (stall !== 1'b0 || res_valid !== 1'b0 || res_hi !== 32'd0 || res_lo !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid_mul: stall=%b valid=%b hi=%h lo=%h, need all zero",
               stall, res_valid, res_hi, res_lo);
    end
    @(posedge clk); #1;
    reset = 1'b0; req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_chk++;
      if (stall !== 1'b0 || res_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_abandon: stall=%b valid=%b, need 0 0", stall, res_valid);
      end
    end
    do_op(MD_MULTU, 32'd7, 32'd9, "mul_after_reset");
    retire(0, "mul_after_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      muldiv_op_t  op;
      logic [31:0] a, b;
      op = muldiv_op_t'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0:       a = 32'h8000_0000;
        1:       a = 32'($urandom_range(0, 20));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 6))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      do_op(op, a, b, "random");
      retire($urandom_range(0, 2), "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_flush_div();
    test_back_to_back();
    test_reset_mid_mul();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 Parameter MUL_LAT, default 2, the number of cycles the MUL state is held before DONE (range 1..4).
REQ-002 Parameter DIV_BITS, default 32, the number of iterations the divider runs, one quotient bit per cycle.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port req_valid, input, 1 bit: the execute stage holds a mult/div instruction; it stays stable while stall=1.
REQ-006 Port req_op, input, 2 bits, type muldiv_op_t: MD_MULT, MD_MULTU, MD_DIV or MD_DIVU.
REQ-007 Port req_a, input, 32 bits: rs operand (multiplicand or dividend).
REQ-008 Port req_b, input, 32 bits: rt operand (multiplier or divisor).
REQ-009 Port flush, input, 1 bit: exception or redirect kill of the execute-stage instruction.
REQ-010 Port advance, input, 1 bit: the execute stage moves to memory this cycle.
REQ-011 Port stall, output, 1 bit: freeze fetch through execute.
REQ-012 Port res_valid, output, 1 bit: res_hi and res_lo are final.
REQ-013 Port res_hi, output, 32 bits: product[63:32] or remainder.
REQ-014 Port res_lo, output, 32 bits: product[31:0] or quotient.

Function
REQ-015 States SHALL be IDLE, MUL, DIV and DONE.
REQ-016 IDLE: on req_valid=1 and flush=0, latch |a|, |b|, the sign flags and op, then go to MUL or DIV.
  - Operands are absolute values for signed ops and raw values for unsigned ops.
REQ-017 IDLE transition for divide-by-zero: a DIV or DIVU with req_b==0 goes directly to DONE.
  - res_hi = req_a, res_lo = 32'hFFFF_FFFF, no sign fix-up.
REQ-018 MUL: compute the 64-bit unsigned product of the latched operands.
  - Hold MUL_LAT cycles, then go to DONE; a product may be registered across those cycles.
REQ-019 DIV: run div_iter for DIV_BITS cycles, then go to DONE.
REQ-020 Signed fix-up at DONE entry:
  - MULT: negate the 64-bit product when the operand signs differ.
  - DIV: negate the quotient when the signs differ; negate the remainder when the dividend is negative.
REQ-021 Edge case 0x8000_0000 DIV 0xFFFF_FFFF SHALL give lo=0x8000_0000 and hi=0.
REQ-022 DONE: res_valid=1 and stall=0.
  - Stay in DONE while advance=0.
  - With advance=1, go to IDLE; a req_valid seen in IDLE on the next cycle is a new instruction.
REQ-023 stall SHALL be 1 when (state==IDLE and req_valid and not flush) or state is MUL or DIV; otherwise 0.
REQ-024 flush=1 in any state SHALL force IDLE on the next edge with stall=0 and res_valid=0 in that cycle; in-flight results are discarded.
REQ-025 flush takes priority over advance and over a new request arriving in the same cycle.
REQ-026 Latency from acceptance to res_valid SHALL be:
  - MUL_LAT+1 cycles for multiply.
  - DIV_BITS+1 cycles for divide.
  - 1 cycle for divide-by-zero.
REQ-027 res_hi and res_lo SHALL hold their value while in DONE and are 0 whenever res_valid=0.

Reset
REQ-028 reset=1 SHALL asynchronously force IDLE, clear all operand and result registers, and clear the counters and div_iter state.
REQ-029 While reset=1: stall=0, res_valid=0, res_hi=0, res_lo=0.
REQ-030 Reset during MUL or DIV SHALL abandon the operation with no output.

Structure
REQ-031 muldiv_op_t, the MD_* encodings and the MUL_LAT and DIV_BITS defaults SHALL live in the shared pipeline package.
REQ-032 One sub-module, div_iter, SHALL implement the unsigned restoring divider.
  - Interface: start, unsigned dividend and divisor, done, quotient, remainder.
  - Sign handling stays in muldiv_ctrl.

Verification
REQ-033 MULT a=0xFFFF_FFFE (-2), b=3 SHALL give stall for 3 cycles, then hi=0xFFFF_FFFF and lo=0xFFFF_FFFA.
REQ-034 DIV a=-7, b=2 SHALL give lo=0xFFFF_FFFD (-3) and hi=0xFFFF_FFFF (-1) after 33 cycles; DIVU of the same operands gives lo=0x7FFF_FFFC, hi=1.
REQ-035 DIVU a=5, b=0 SHALL give res_valid on the next cycle with hi=5 and lo=0xFFFF_FFFF.
REQ-036 flush asserted at DIV cycle 10 SHALL give stall=0 that cycle, IDLE next, and no res_valid.
  - A MULTU 0xFFFF_FFFF x 0xFFFF_FFFF issued next gives hi=0xFFFF_FFFE, lo=1.
REQ-037 DONE with advance=0 held for 5 cycles SHALL keep the result stable.
  - Then advance=1 plus back-to-back MULT 2x3 gives a fresh lo=6 after MUL_LAT+1 cycles.
REQ-038 reset pulsed mid-MUL SHALL zero all outputs immediately, without waiting for a clock edge.
